// File: rtl/regfile_useq.sv
// Macro-op sequencer for the register-file decoder: expands a 3-bit macro-op
// into a short stream of instruction nibbles, with issue stalls via hold.
module regfile_useq (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] op,
  input  logic [3:0] imm_a,
  input  logic [3:0] imm_b,
  input  logic [3:0] imm_op,
  input  logic       hold,
  output logic       op_ready,
  output logic [3:0] instr,
  output logic [3:0] imm_out,
  output logic       instr_valid,
  output logic       instr_last
);

  // state | meaning
  // IDLE  | waiting for a macro-op, op_ready high
  // ISSUE | stepping through the latched macro-op, one instruction per unheld cycle
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t     state, state_n;
  logic [1:0] step, step_n;
  logic [2:0] op_q;
  logic [3:0] imm_a_q, imm_b_q, imm_op_q;
  logic       accept;
  logic       at_last;
  logic [3:0] seq_nibble;

  function automatic logic [3:0] seq_instr(input logic [2:0] o, input logic [1:0] s);
    case (o)
      3'd0:    seq_instr = 4'h0;
      3'd1:    seq_instr = (s == 2'd0) ? 4'h1 : 4'h2;
      3'd2:    seq_instr = {2'b00, s} + 4'h1;
      3'd3:    seq_instr = 4'h9;
      3'd4:    seq_instr = 4'hB;
      3'd5:    seq_instr = 4'h8;
      3'd6:    seq_instr = 4'hF;
      default: seq_instr = (s == 2'd0) ? 4'hF : {2'b00, s};
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [2:0] o);
    case (o)
      3'd1:    last_step = 2'd1;
      3'd2:    last_step = 2'd2;
      3'd7:    last_step = 2'd3;
      default: last_step = 2'd0;
    endcase
  endfunction

  assign accept     = (state == IDLE) && op_valid;
  assign at_last    = (step == last_step(op_q));
  assign seq_nibble = seq_instr(op_q, step);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= 2'd0;
      op_q     <= 3'd0;
      imm_a_q  <= 4'd0;
      imm_b_q  <= 4'd0;
      imm_op_q <= 4'd0;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (accept) begin
        op_q     <= op;
        imm_a_q  <= imm_a;
        imm_b_q  <= imm_b;
        imm_op_q <= imm_op;
      end
    end
  end

  // Step only advances when not on the final step, so it cannot wrap.
  always_comb begin
    state_n = state;
    step_n  = step;
    case (state)
      IDLE: begin
        if (op_valid) begin
          state_n = ISSUE;
          step_n  = 2'd0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          if (at_last) begin
            state_n = IDLE;
            step_n  = 2'd0;
          end else begin
            step_n = step + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    op_ready    = 1'b0;
    instr       = 4'h0;
    imm_out     = 4'h0;
    instr_valid = 1'b0;
    instr_last  = 1'b0;
    case (state)
      IDLE: op_ready = 1'b1;
      ISSUE: begin
        if (!hold) begin
          instr       = seq_nibble;
          instr_valid = 1'b1;
          instr_last  = at_last;
          case (seq_nibble)
            4'h1:    imm_out = imm_a_q;
            4'h2:    imm_out = imm_b_q;
            4'h3:    imm_out = imm_op_q;
            default: imm_out = 4'h0;
          endcase
        end
      end
      default: op_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_regfile_useq.sv
// Self-checking bench for regfile_useq: table-driven op sweep plus
// hand-written hold, back-to-back, ignore-during-issue and reset sequences.
module tb_regfile_useq;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [2:0] op;
  logic [3:0] imm_a, imm_b, imm_op;
  logic       hold;
  logic       op_ready;
  logic [3:0] instr;
  logic [3:0] imm_out;
  logic       instr_valid;
  logic       instr_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_useq dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .imm_a(imm_a), .imm_b(imm_b), .imm_op(imm_op), .hold(hold),
    .op_ready(op_ready), .instr(instr), .imm_out(imm_out),
    .instr_valid(instr_valid), .instr_last(instr_last)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  a, b, o;
    int          len;
    logic [15:0] exp_instr;  // step k in nibble k
    logic [15:0] exp_imm;
  } vec_t;

  vec_t vecs [8];

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk1({name, ".op_ready"}, op_ready, 1'b1);
    chk4({name, ".instr"}, instr, 4'h0);
    chk4({name, ".imm_out"}, imm_out, 4'h0);
    chk1({name, ".valid"}, instr_valid, 1'b0);
    chk1({name, ".last"}, instr_last, 1'b0);
  endtask

  task automatic chk_step(input string name, input logic [3:0] ei, input logic [3:0] em,
                          input logic ev, input logic el);
    chk4({name, ".instr"}, instr, ei);
    chk4({name, ".imm_out"}, imm_out, em);
    chk1({name, ".valid"}, instr_valid, ev);
    chk1({name, ".last"}, instr_last, el);
    chk1({name, ".op_ready"}, op_ready, 1'b0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] io);
    op_valid = 1'b1; op = o; imm_a = a; imm_b = b; imm_op = io;
    tick();
    op_valid = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{3'd0, 4'h1, 4'h2, 4'h3, 1, 16'h0000, 16'h0000};
    vecs[1] = '{3'd1, 4'h5, 4'hA, 4'h3, 2, 16'h0021, 16'h00A5};
    vecs[2] = '{3'd2, 4'h5, 4'hA, 4'h3, 3, 16'h0321, 16'h03A5};
    vecs[3] = '{3'd3, 4'h7, 4'h8, 4'h9, 1, 16'h0009, 16'h0000};
    vecs[4] = '{3'd4, 4'h7, 4'h8, 4'h9, 1, 16'h000B, 16'h0000};
    vecs[5] = '{3'd5, 4'h7, 4'h8, 4'h9, 1, 16'h0008, 16'h0000};
    vecs[6] = '{3'd6, 4'h1, 4'h2, 4'h3, 1, 16'h000F, 16'h0000};
    vecs[7] = '{3'd7, 4'hC, 4'hD, 4'hE, 4, 16'h321F, 16'hEDC0};

    rst = 1'b1; op_valid = 1'b1; op = 3'd7; imm_a = 4'hF; imm_b = 4'hF; imm_op = 4'hF;
    hold = 1'b0;
    tick();
    tick();
    // reset wins over a pending op_valid
    chk_idle("reset");
    rst = 1'b0; op_valid = 1'b0;
    tick();
    chk_idle("post_reset");

    // Sweep all ops; count valid steps until op_ready returns, bounded.
    for (int v = 0; v < 8; v++) begin
      int cnt;
      int cyc;
      cnt = 0;
      cyc = 0;
      chk1($sformatf("sweep%0d.ready_before", v), op_ready, 1'b1);
      issue(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].o);
      while (!op_ready && cyc < 8) begin
        if (instr_valid) begin
          if (cnt < 4) begin
            chk4($sformatf("sweep%0d.instr%0d", v, cnt), instr, vecs[v].exp_instr[4*cnt +: 4]);
            chk4($sformatf("sweep%0d.imm%0d", v, cnt), imm_out, vecs[v].exp_imm[4*cnt +: 4]);
          end
          chk1($sformatf("sweep%0d.last%0d", v, cnt), instr_last, (cnt == vecs[v].len - 1));
          cnt++;
        end
        tick();
        cyc++;
      end
      chk_int($sformatf("sweep%0d.count", v), cnt, vecs[v].len);
      chk_int($sformatf("sweep%0d.cycles", v), cyc, vecs[v].len);
      chk_idle($sformatf("sweep%0d.idle", v));
    end

    // LOAD_ALL with immediates 5/A/3
    issue(3'd2, 4'h5, 4'hA, 4'h3);
    chk_step("la.s0", 4'h1, 4'h5, 1'b1, 1'b0);
    tick();
    chk_step("la.s1", 4'h2, 4'hA, 1'b1, 1'b0);
    tick();
    chk_step("la.s2", 4'h3, 4'h3, 1'b1, 1'b1);
    tick();
    chk_idle("la.done");

    // CLEAR_LOAD with two hold cycles after the first step
    issue(3'd7, 4'h4, 4'h6, 4'h2);
    chk_step("hold.s0", 4'hF, 4'h0, 1'b1, 1'b0);
    tick();
    hold = 1'b1; #1;
    chk_step("hold.h0", 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    chk_step("hold.h1", 4'h0, 4'h0, 1'b0, 1'b0);
    tick();
    hold = 1'b0; #1;
    chk_step("hold.s1", 4'h1, 4'h4, 1'b1, 1'b0);
    tick();
    chk_step("hold.s2", 4'h2, 4'h6, 1'b1, 1'b0);
    tick();
    chk_step("hold.s3", 4'h3, 4'h2, 1'b1, 1'b1);
    tick();
    chk_idle("hold.done");

    // Back-to-back COPY_A_B then RES_TO_A with op_valid held
    chk1("b2b.r0", op_ready, 1'b1);
    op_valid = 1'b1; op = 3'd3; imm_a = 4'h0; imm_b = 4'h0; imm_op = 4'h0;
    tick();
    chk_step("b2b.cp", 4'h9, 4'h0, 1'b1, 1'b1);
    op = 3'd4;
    tick();
    chk_idle("b2b.gap");
    tick();
    chk_step("b2b.ra", 4'hB, 4'h0, 1'b1, 1'b1);
    op_valid = 1'b0;
    tick();
    chk_idle("b2b.done");

    // Inputs changed during ISSUE must not disturb the sequence
    issue(3'd1, 4'h6, 4'h7, 4'h1);
    op_valid = 1'b1; op = 3'd6; imm_a = 4'hF; imm_b = 4'hE; #1;
    chk_step("ign.s0", 4'h1, 4'h6, 1'b1, 1'b0);
    tick();
    chk_step("ign.s1", 4'h2, 4'h7, 1'b1, 1'b1);
    tick();
    chk_idle("ign.idle");
    tick();
    op_valid = 1'b0; #1;
    chk_step("ign.clr", 4'hF, 4'h0, 1'b1, 1'b1);
    tick();
    chk_idle("ign.done");

    // Reset during step 2 of CLEAR_LOAD aborts with nothing injected
    issue(3'd7, 4'h9, 4'h9, 4'h9);
    chk_step("rst.s0", 4'hF, 4'h0, 1'b1, 1'b0);
    tick();
    chk_step("rst.s1", 4'h1, 4'h9, 1'b1, 1'b0);
    tick();
    chk_step("rst.s2", 4'h2, 4'h9, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk_idle("rst.after");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("rst.quiet%0d", i), instr_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_useq.md
REGFILE_USEQ -- requirements
Module: regfile_useq

Interface
REQ-001 The block SHALL have the port `clk  input  1`: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port `rst  input  1`: reset, synchronous and active-high.
REQ-003 The block SHALL have the port `op_valid  input  1`: a macro-op request is present.
REQ-004 The block SHALL have the port `op  input  3`: macro-op code, per REQ-012.
REQ-005 The block SHALL have the port `imm_a, imm_b, imm_op  input  4 each`: immediates for the A, B and OP loads.
REQ-006 The block SHALL have the port `hold  input  1`: stalls instruction issue.
REQ-007 The block SHALL have the port `op_ready  output  1`: the block can accept a macro-op.
REQ-008 The block SHALL have the port `instr  output  4`: register-file instruction nibble, using the register-file decoder encoding.
REQ-009 The block SHALL have the port `imm_out  output  4`: immediate aligned with the current LDI instruction; 0 otherwise.
REQ-010 The block SHALL have the port `instr_valid  output  1`: `instr` is a real issued step.
REQ-011 The block SHALL have the port `instr_last  output  1`: the current issued step is the final step of the macro-op.

Function
REQ-012 Macro-op sequences SHALL be (step order, `instr` hex):
- 0 NOP: 0
- 1 LOAD_AB: 1, 2
- 2 LOAD_ALL: 1, 2, 3
- 3 COPY_A_B: 9
- 4 RES_TO_A: B
- 5 RES_TO_BUS: 8
- 6 CLEAR: F
- 7 CLEAR_LOAD: F, 1, 2, 3
REQ-013 The FSM SHALL have exactly two states, IDLE and ISSUE, plus a 2-bit step counter.
REQ-014 In IDLE, `op_ready`=1, `instr`=0, `instr_valid`=0, `instr_last`=0 and `imm_out`=0.
REQ-015 Acceptance SHALL occur on a rising edge with `op_valid`=1 and `op_ready`=1. At that edge the block latches `op`, `imm_a`, `imm_b` and `imm_op`, clears the step counter to 0 and moves to ISSUE.
REQ-016 In ISSUE, `op_ready` SHALL be 0, and `op_valid` SHALL be ignored.
REQ-017 In ISSUE with `hold`=0, the block SHALL drive `instr` from the latched op and the current step, with `instr_valid`=1. The step counter advances by 1 each cycle.
REQ-018 `imm_out` SHALL equal the latched `imm_a` when `instr`=1, `imm_b` when `instr`=2 and `imm_op` when `instr`=3, and 0 for every other instruction.
REQ-019 In ISSUE with `hold`=1, the block SHALL drive `instr`=0, `imm_out`=0, `instr_valid`=0 and `instr_last`=0, and the step counter SHALL NOT advance.
REQ-020 `instr_last`=1 SHALL be asserted exactly when `instr_valid`=1 and step = length-1. On that edge the FSM returns to IDLE.
REQ-021 Latency: for acceptance at edge N with no hold, step k SHALL be presented in cycle N+1+k, and `op_ready`=1 again in cycle N+1+length.
REQ-022 Throughput: back-to-back ops SHALL take length+1 cycles each; there is no skid buffer.
REQ-023 Changes on `op`, `op_valid` or any `imm_*` input during ISSUE SHALL NOT affect the sequence in flight.
REQ-024 All outputs SHALL be registered-state decodes only, with no combinational path from inputs to outputs except `hold` to `instr`, `imm_out`, `instr_valid` and `instr_last`.
REQ-025 The step counter SHALL never exceed length-1; wrap-around SHALL be impossible by construction.

Reset
REQ-026 With `rst`=1 at a rising edge, the FSM SHALL go to IDLE, the step counter and latched op/immediates SHALL clear to 0, and reset SHALL take priority over acceptance and issue.
REQ-027 Reset mid-sequence SHALL abort the sequence; no further steps are issued, and no CLEAR (F) is injected.
REQ-028 In the cycle after reset, the outputs SHALL be `op_ready`=1, `instr`=0, `imm_out`=0, `instr_valid`=0 and `instr_last`=0.

Verification
REQ-029 Bench scenario: op=2, imm_a=5, imm_b=A, imm_op=3, hold=0 -> `instr` sequence 1, 2, 3 with `imm_out` 5, A, 3; `instr_last` on the third step; `op_ready` high one cycle later.
REQ-030 Bench scenario: op=7, hold=1 for 2 cycles after the first step -> `instr` sequence F, 0, 0, 1, 2, 3 with `instr_valid` sequence 1, 0, 0, 1, 1, 1; 4 valid steps total.
REQ-031 Bench scenario: back-to-back op=3 then op=4 with `op_valid` held high -> 9 (last), then idle cycle, then B (last); `op_ready` toggles 1, 0, 1, 0, 1.
REQ-032 Bench scenario: op=1 accepted, then op=6 and imm_a=F applied during ISSUE -> still 1, 2 with the original `imm_a`; op=6 accepted only after return to IDLE.
REQ-033 Bench scenario: op=7 with `rst`=1 during step 2 -> next cycle `instr`=0, `op_ready`=1, and no remaining steps issued.
REQ-034 Bench scenario: all 8 op codes swept -> instruction sequences and lengths match REQ-012 exactly, and `instr_valid` count equals length.
